// File: rtl/program_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | program_loader_pkg : shared loader FSM encoding and frame constants         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    // A frame is good when instruction bytes plus the CSUM byte sum to this value.
    localparam logic [7:0] C_CSUM_RESIDUE = 8'h00;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/program_loader_checksum_acc.sv
// +----------------------------------------------------------------------------+
// | program_loader_checksum_acc : mod-2^W byte accumulator with zero look-ahead |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader_checksum_acc
    import program_loader_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic         zero
);

    logic [W-1:0] r_sum;
    logic [W-1:0] w_sum_next;

    assign w_sum_next = r_sum + data;

    // Flags whether the running sum would reach the residue once 'data' is added,
    // so the CSUM byte can be judged in the same cycle it is accepted.
    assign zero = (w_sum_next == W'(C_CSUM_RESIDUE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clear) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= w_sum_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// +----------------------------------------------------------------------------+
// | program_loader : streams a LEN/DATA/CSUM image into instruction memory      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_wr_en,
    output logic [ADDR_W-1:0] im_wr_addr,
    output logic [DATA_W-1:0] im_wr_data,
    output logic [ADDR_W-1:0] last_add,
    output logic              cpu_power,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;

    logic w_xfer;
    logic w_last_byte;
    logic w_acc_clear;
    logic w_sum_zero;
    logic w_len_xfer;
    logic w_data_xfer;
    logic w_csum_pass;
    logic w_csum_fail;

    assign in_ready    = is_busy(r_state);
    assign busy        = is_busy(r_state);
    assign w_xfer      = in_valid & in_ready;
    assign w_last_byte = (r_idx == r_count);

    program_loader_checksum_acc #(
        .W (DATA_W)
    ) u_checksum_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_acc_clear),
        .en    (w_data_xfer),
        .data  (in_data),
        .zero  (w_sum_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // load_start takes priority over any transfer presented in the same cycle.
    always_comb begin
        w_next      = r_state;
        w_acc_clear = 1'b0;
        w_len_xfer  = 1'b0;
        w_data_xfer = 1'b0;
        w_csum_pass = 1'b0;
        w_csum_fail = 1'b0;
        if (load_start) begin
            w_next      = ST_LEN;
            w_acc_clear = 1'b1;
        end else if (w_xfer) begin
            case (r_state)
                ST_LEN: begin
                    w_len_xfer = 1'b1;
                    w_next     = ST_DATA;
                end
                ST_DATA: begin
                    w_data_xfer = 1'b1;
                    if (w_last_byte) begin
                        w_next = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_sum_zero) begin
                        w_csum_pass = 1'b1;
                        w_next      = ST_DONE;
                    end else begin
                        w_csum_fail = 1'b1;
                        w_next      = ST_ERR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The index stops on the final byte, so a full 2^ADDR_W image never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_idx      <= '0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            last_add   <= '0;
            cpu_power  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            im_wr_en <= 1'b0;
            if (load_start) begin
                r_idx     <= '0;
                cpu_power <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
            end
            if (w_len_xfer) begin
                r_count <= ADDR_W'(in_data);
            end
            if (w_data_xfer) begin
                im_wr_en   <= 1'b1;
                im_wr_addr <= r_idx;
                im_wr_data <= in_data;
                if (!w_last_byte) begin
                    r_idx <= r_idx + ADDR_W'(1);
                end
            end
            if (w_csum_pass) begin
                done      <= 1'b1;
                cpu_power <= 1'b1;
                last_add  <= r_count;
            end
            if (w_csum_fail) begin
                err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// +----------------------------------------------------------------------------+
// | tb_program_loader : frame-level reference model bench for program_loader   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_program_loader;

    typedef logic [7:0] frame_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       im_wr_en;
    logic [7:0] im_wr_addr;
    logic [7:0] im_wr_data;
    logic [7:0] last_add;
    logic       cpu_power;
    logic       busy;
    logic       done;
    logic       err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] got[$];
    logic [7:0]  exp_last_add;

    program_loader #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .last_add   (last_add),
        .cpu_power  (cpu_power),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && im_wr_en === 1'b1) begin
            got.push_back({im_wr_addr, im_wr_data});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", in_ready, 1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    function automatic frame_t make_frame(input int n, input bit good);
        frame_t     f;
        int         sum;
        logic [7:0] b;
        sum = 0;
        f.push_back(8'(n - 1));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            sum += int'(b);
        end
        b = 8'((256 - (sum % 256)) % 256);
        if (!good) begin
            b = b + 8'($urandom_range(1, 255));
        end
        f.push_back(b);
        return f;
    endfunction

    // Reference: N = LEN+1 writes of f[1..N] at 0..N-1; good iff byte sum mod 256 is 0.
    task automatic run_frame(input frame_t f, input int max_gap, input bit do_start);
        int n;
        int sum;
        bit ok;
        got.delete();
        if (do_start) begin
            pulse_start();
            check_eq("busy_after_start", busy, 1);
            check_eq("cpu_held_in_load", cpu_power, 0);
            check_eq("done_cleared", done, 0);
        end
        foreach (f[i]) begin
            send_byte(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        n   = int'(f[0]) + 1;
        sum = 0;
        for (int i = 1; i <= n + 1; i++) begin
            sum += int'(f[i]);
        end
        ok = ((sum % 256) == 0);
        if (ok) begin
            exp_last_add = f[0];
        end
        check_eq("wr_count", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            check_eq("wr_addr", got[i][15:8], i);
            check_eq("wr_data", got[i][7:0], f[i+1]);
        end
        check_eq("done", done, ok);
        check_eq("err", err, !ok);
        check_eq("cpu_power", cpu_power, ok);
        check_eq("last_add", last_add, exp_last_add);
        check_eq("busy_idle", busy, 0);
        check_eq("ready_idle", in_ready, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_wr_en"}, im_wr_en, 0);
        check_eq({tag, "_wr_addr"}, im_wr_addr, 0);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_cpu_power"}, cpu_power, 0);
        check_eq({tag, "_last_add"}, last_add, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f1;
        frame_t f2;
        frame_t f4;
        frame_t fr;

        rst_n        = 1'b1;
        load_start   = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        exp_last_add = 8'h00;
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        f1.push_back(8'h02);
        f1.push_back(8'h01);
        f1.push_back(8'h12);
        f1.push_back(8'h23);
        f1.push_back(8'hCA);
        f2 = f1;
        f2[4] = 8'hCB;
        f4.push_back(8'hFF);
        for (int i = 0; i < 256; i++) begin
            f4.push_back(8'(i));
        end
        f4.push_back(8'h80);

        run_frame(f1, 0, 1'b1);
        run_frame(f4, 0, 1'b1);
        run_frame(f2, 0, 1'b1);
        run_frame(f1, 3, 1'b1);

        // Abort after two data bytes; the restart pulse coincides with a presented byte.
        got.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        in_data    = 8'h55;
        in_valid   = 1'b1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        check_eq("abort_wr_count", got.size(), 2);
        check_eq("abort_wr_addr1", got[1][15:8], 8'h01);
        check_eq("abort_wr_data1", got[1][7:0], 8'h12);
        check_eq("abort_ready", in_ready, 1);
        check_eq("abort_cpu_power", cpu_power, 0);
        @(posedge clk); #1;
        run_frame(f1, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            fr = make_frame(int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)));
            run_frame(fr, 2, 1'b1);
        end

        // Asynchronous reset mid-DATA with a write strobe pending.
        run_frame(f1, 0, 1'b1);
        pulse_start();
        send_byte(8'h09, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        rst_n = 1'b0;
        #1 check_all_zero("midload_reset");
        exp_last_add = 8'h00;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(f1, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
